// File: rtl/nms_pkg.sv
// nms_pkg: shared widths, pixel field layout and controller state encoding
// for the 3x3 NMS sequencing controller.
package nms_pkg;

    localparam int CW         = 10;  // coordinate field width
    localparam int SCORE_W    = 13;  // corner score width
    localparam int PIX_W      = 2*CW + 1 + SCORE_W;

    // Bit offsets of the fields inside the 34-bit buffer word
    localparam int X_LSB      = 24;
    localparam int Y_LSB      = 14;
    localparam int CORNER_BIT = 13;
    localparam int SCORE_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESYNC = 2'd3
    } nms_state_e;

endpackage

// File: rtl/nms_pos_cnt.sv
// nms_pos_cnt: column/row position counter for one frame.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   en            advance one pixel
//   clr           return to (0,0); wins over en
//   x, y          current pixel position
//   last_col      x is the last column of a line
//   last_pix      x,y is the last pixel of the frame
// The last pixel wraps back to (0,0) so the next frame starts clean.
module nms_pos_cnt #(
    parameter int COL_NUM = 640,
    parameter int ROW_NUM = 480,
    parameter int CW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          last_col,
    output logic          last_pix
);

    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;

    assign last_col = (x_q == CW'(COL_NUM - 1));
    assign last_pix = last_col && (y_q == CW'(ROW_NUM - 1));
    assign x        = x_q;
    assign y        = y_q;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            if (last_pix) begin
                x_d = '0;
                y_d = '0;
            end else if (last_col) begin
                x_d = '0;
                y_d = y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/nms_ctrl.sv
// nms_ctrl: sequencing controller for the 3x3 NMS line-buffer/window path.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   in_valid/in_ready             upstream pixel handshake
//   in_sof, in_corner, in_score   pixel sideband and payload
//   buf_ce, buf_rst, buf_data     window buffer shift, reset, tagged pixel
//   win_vld/win_ready             complete interior window to comparator
//   win_x, win_y                  window centre coordinates
//   frame_done                    pulse after the last window handshake
//   sync_err                      pulse on a mid-frame sof
//   busy                          controller not idle
module nms_ctrl
    import nms_pkg::*;
#(
    parameter int COL_NUM  = 640,
    parameter int ROW_NUM  = 480,
    parameter int NMS_SIZE = 3,
    parameter int CW       = nms_pkg::CW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sof,
    input  logic                    in_corner,
    input  logic [SCORE_W-1:0]      in_score,
    output logic                    buf_ce,
    output logic                    buf_rst,
    output logic [2*CW+SCORE_W:0]   buf_data,
    output logic                    win_vld,
    input  logic                    win_ready,
    output logic [CW-1:0]           win_x,
    output logic [CW-1:0]           win_y,
    output logic                    frame_done,
    output logic                    sync_err,
    output logic                    busy
);

    if (NMS_SIZE != 3) begin : g_size_chk
        $error("nms_ctrl: only NMS_SIZE=3 is supported");
    end

    nms_state_e    state_q, state_d;
    logic          win_vld_q, win_vld_d;
    logic [CW-1:0] win_x_q, win_x_d;
    logic [CW-1:0] win_y_q, win_y_d;
    logic          frame_done_q, frame_done_d;
    logic          sync_err_q, sync_err_d;

    logic [CW-1:0] x_cnt, y_cnt;
    logic          last_col, last_pix;
    logic          cnt_clr;
    logic          mid_sof;
    logic          win_qual;

    nms_pos_cnt #(
        .COL_NUM (COL_NUM),
        .ROW_NUM (ROW_NUM),
        .CW      (CW)
    ) u_pos_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (buf_ce),
        .clr      (cnt_clr),
        .x        (x_cnt),
        .y        (y_cnt),
        .last_col (last_col),
        .last_pix (last_pix)
    );

    // A sof inside a running frame is refused and forces a resync.
    assign mid_sof  = (state_q == ST_RUN) && in_valid && in_sof &&
                      ((x_cnt != '0) || (y_cnt != '0));
    // Pixel (c,r) with c>=2, r>=2 completes the window centred at (c-1,r-1).
    assign win_qual = (x_cnt >= CW'(2)) && (y_cnt >= CW'(2));

    assign buf_data   = {x_cnt, y_cnt, in_corner, in_score};
    assign buf_rst    = !rst || (state_q == ST_RESYNC);
    assign busy       = (state_q != ST_IDLE);
    assign win_vld    = win_vld_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        cnt_clr      = 1'b0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && in_sof)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mid_sof) begin
                    sync_err_d = 1'b1;
                    state_d    = ST_RESYNC;
                end else begin
                    // A pending window freezes the buffer until consumed.
                    in_ready = !win_vld_q || win_ready;
                    if (in_valid && in_ready && last_col && last_pix)
                        state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!win_vld_q || win_ready) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_RESYNC: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        buf_ce = in_valid && in_ready &&
                 ((state_q == ST_RUN) || ((state_q == ST_IDLE) && in_sof));

        win_vld_d = win_vld_q;
        win_x_d   = win_x_q;
        win_y_d   = win_y_q;
        if (mid_sof) begin
            win_vld_d = 1'b0;
        end else if (buf_ce && win_qual) begin
            win_vld_d = 1'b1;
            win_x_d   = x_cnt - CW'(1);
            win_y_d   = y_cnt - CW'(1);
        end else if (win_vld_q && win_ready) begin
            win_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            win_vld_q    <= 1'b0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_vld_q    <= win_vld_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

endmodule

// File: tb/tb_nms_ctrl.sv
// tb_nms_ctrl: directed bench for nms_ctrl on an 8x6 frame.
module tb_nms_ctrl;

    localparam int COLS = 8;
    localparam int ROWS = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sof = 1'b0;
    logic        in_corner = 1'b0;
    logic [12:0] in_score = '0;
    logic        buf_ce, buf_rst;
    logic [33:0] buf_data;
    logic        win_vld;
    logic        win_ready = 1'b1;
    logic [9:0]  win_x, win_y;
    logic        frame_done, sync_err, busy;

    nms_ctrl #(.COL_NUM(COLS), .ROW_NUM(ROWS), .NMS_SIZE(3), .CW(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_corner(in_corner), .in_score(in_score),
        .buf_ce(buf_ce), .buf_rst(buf_rst), .buf_data(buf_data),
        .win_vld(win_vld), .win_ready(win_ready), .win_x(win_x), .win_y(win_y),
        .frame_done(frame_done), .sync_err(sync_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor: log window handshakes and pulse counts, sampled mid-cycle.
    int win_n = 0, fd_n = 0, se_n = 0, br_n = 0;
    int wx [0:511];
    int wy [0:511];
    always @(negedge clk) begin
        if (rst && win_vld && win_ready) begin
            if (win_n < 512) begin
                wx[win_n] = int'(win_x);
                wy[win_n] = int'(win_y);
            end
            win_n++;
        end
        if (frame_done) fd_n++;
        if (sync_err)   se_n++;
        if (buf_rst)    br_n++;
    end

    int          stalls = 0;
    logic        acc_ce;
    logic [33:0] acc_data;

    // Present one beat, hold until accepted; returns 1ns after the edge.
    task automatic send_beat(input logic sof, input logic corner, input logic [12:0] score);
        bit got = 0;
        in_valid = 1'b1; in_sof = sof; in_corner = corner; in_score = score;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            acc_ce = buf_ce; acc_data = buf_data;
            if (in_ready) begin got = 1; break; end
            stalls++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL beat_timeout: in_ready stayed 0, required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_range(input int first, input int last);
        for (int i = first; i <= last; i++)
            send_beat(i == 0, i[0], 13'(i * 37));
    endtask

    task automatic drain_wait();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; win_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (win_vld !== 1'b0) begin errors++; $display("FAIL rst_win_vld: got %b want 0", win_vld); end
        checks++; if (win_x !== 10'd0 || win_y !== 10'd0) begin errors++; $display("FAIL rst_win_xy: got %0d,%0d want 0,0", win_x, win_y); end
        checks++; if (frame_done !== 1'b0 || sync_err !== 1'b0) begin errors++; $display("FAIL rst_pulses: got fd=%b se=%b want 0,0", frame_done, sync_err); end
        checks++; if (buf_rst !== 1'b1) begin errors++; $display("FAIL rst_buf_rst: got %b want 1", buf_rst); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (buf_rst !== 1'b0) begin errors++; $display("FAIL rst_release_buf_rst: got %b want 0", buf_rst); end
        @(posedge clk); #1;
    endtask

    task automatic test_clean_frame();
        int b = win_n, f = fd_n, s0 = stalls;
        logic [33:0] exp_data = {10'd7, 10'd5, 1'b1, 13'h1ABC};
        send_range(0, 17);
        checks++; if (win_vld !== 1'b0) begin errors++; $display("FAIL clean_no_early_win: got %b want 0", win_vld); end
        send_range(18, 18);
        checks++; if (win_vld !== 1'b1 || win_x !== 10'd1 || win_y !== 10'd1) begin
            errors++; $display("FAIL clean_first_win: got vld=%b (%0d,%0d) want 1 (1,1)", win_vld, win_x, win_y); end
        send_range(19, 46);
        send_beat(1'b0, 1'b1, 13'h1ABC);
        checks++; if (acc_ce !== 1'b1 || acc_data !== exp_data) begin
            errors++; $display("FAIL buf_data_7_5: got ce=%b %h want 1 %h", acc_ce, acc_data, exp_data); end
        checks++; if (win_vld !== 1'b1 || win_x !== 10'd6 || win_y !== 10'd4) begin
            errors++; $display("FAIL clean_last_win: got vld=%b (%0d,%0d) want 1 (6,4)", win_vld, win_x, win_y); end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL clean_drain: got busy=%b rdy=%b want 1,0", busy, in_ready); end
        @(posedge clk); #1;
        checks++; if (frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL clean_frame_done: got fd=%b busy=%b want 1,0", frame_done, busy); end
        drain_wait();
        checks++; if (win_n - b !== 24) begin errors++; $display("FAIL clean_win_count: got %0d want 24", win_n - b); end
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (wx[(b+k)%512] !== k%6+1 || wy[(b+k)%512] !== k/6+1) begin
                errors++; $display("FAIL clean_win_order[%0d]: got (%0d,%0d) want (%0d,%0d)", k, wx[(b+k)%512], wy[(b+k)%512], k%6+1, k/6+1); end
        end
        checks++; if (fd_n - f !== 1) begin errors++; $display("FAIL clean_fd_count: got %0d want 1", fd_n - f); end
        checks++; if (stalls - s0 !== 0) begin errors++; $display("FAIL clean_in_ready_drop: got %0d stalls want 0", stalls - s0); end
    endtask

    task automatic test_idle_drop();
        int b = win_n, f = fd_n;
        for (int i = 0; i < 3; i++) begin
            send_beat(1'b0, 1'b1, 13'h0055);
            checks++; if (acc_ce !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL idle_drop[%0d]: got ce=%b busy=%b want 0,0", i, acc_ce, busy); end
        end
        send_range(0, 0);
        checks++; if (acc_ce !== 1'b1 || acc_data[33:14] !== 20'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL idle_sof_tag: got ce=%b xy=%h busy=%b want 1 0 1", acc_ce, acc_data[33:14], busy); end
        send_range(1, 47);
        drain_wait();
        checks++; if (win_n - b !== 24 || fd_n - f !== 1) begin
            errors++; $display("FAIL idle_frame: got wins=%0d fd=%0d want 24,1", win_n - b, fd_n - f); end
    endtask

    task automatic test_backpressure();
        int b = win_n;
        bit found = 0;
        fork
            send_range(0, 47);
            begin
                for (int t = 0; t < 400 && !found; t++) begin
                    @(posedge clk); #1;
                    if (win_vld && win_x == 10'd3 && win_y == 10'd2) found = 1;
                end
                checks++; if (!found) begin errors++; $display("FAIL bp_find_win: got none want (3,2)"); end
                if (found) begin
                    win_ready = 1'b0;
                    for (int c = 0; c < 5; c++) begin
                        @(negedge clk);
                        checks++;
                        if (win_vld !== 1'b1 || win_x !== 10'd3 || win_y !== 10'd2 || in_ready !== 1'b0 || buf_ce !== 1'b0) begin
                            errors++; $display("FAIL bp_hold[%0d]: got vld=%b (%0d,%0d) rdy=%b ce=%b want 1 (3,2) 0 0", c, win_vld, win_x, win_y, in_ready, buf_ce); end
                        @(posedge clk); #1;
                    end
                    win_ready = 1'b1;
                end
            end
        join
        drain_wait();
        checks++; if (win_n - b !== 24) begin errors++; $display("FAIL bp_win_count: got %0d want 24", win_n - b); end
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (wx[(b+k)%512] !== k%6+1 || wy[(b+k)%512] !== k/6+1) begin
                errors++; $display("FAIL bp_win_order[%0d]: got (%0d,%0d) want (%0d,%0d)", k, wx[(b+k)%512], wy[(b+k)%512], k%6+1, k/6+1); end
        end
    endtask

    task automatic test_resync();
        int b, s, br, f;
        send_range(0, 28);                 // up to pixel (4,3); window (3,2) pending
        win_ready = 1'b0;
        b = win_n; s = se_n; br = br_n; f = fd_n;
        in_valid = 1'b1; in_sof = 1'b1; in_corner = 1'b0; in_score = '0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || buf_ce !== 1'b0 || win_vld !== 1'b1) begin
            errors++; $display("FAIL resync_refuse: got rdy=%b ce=%b vld=%b want 0 0 1", in_ready, buf_ce, win_vld); end
        @(posedge clk); #1;
        checks++; if (sync_err !== 1'b1 || win_vld !== 1'b0 || buf_rst !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL resync_state: got se=%b vld=%b brst=%b rdy=%b want 1 0 1 0", sync_err, win_vld, buf_rst, in_ready); end
        win_ready = 1'b1;
        send_beat(1'b1, 1'b0, 13'd0);
        checks++; if (acc_ce !== 1'b1 || acc_data[33:14] !== 20'd0) begin
            errors++; $display("FAIL resync_sof_tag: got ce=%b xy=%h want 1 0", acc_ce, acc_data[33:14]); end
        checks++; if (sync_err !== 1'b0 || buf_rst !== 1'b0) begin
            errors++; $display("FAIL resync_pulse_end: got se=%b brst=%b want 0 0", sync_err, buf_rst); end
        send_range(1, 47);
        drain_wait();
        checks++; if (se_n - s !== 1 || br_n - br !== 1) begin
            errors++; $display("FAIL resync_pulses: got se=%0d brst=%0d want 1,1", se_n - s, br_n - br); end
        checks++; if (win_n - b !== 24 || fd_n - f !== 1) begin
            errors++; $display("FAIL resync_frame: got wins=%0d fd=%0d want 24,1", win_n - b, fd_n - f); end
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (wx[(b+k)%512] !== k%6+1 || wy[(b+k)%512] !== k/6+1) begin
                errors++; $display("FAIL resync_win_order[%0d]: got (%0d,%0d) want (%0d,%0d)", k, wx[(b+k)%512], wy[(b+k)%512], k%6+1, k/6+1); end
        end
    endtask

    task automatic test_reset_mid();
        int b, f;
        send_range(0, 35);                 // next pixel would be (4,4)
        f = fd_n;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (buf_rst !== 1'b1) begin errors++; $display("FAIL midrst_buf_rst: got %b want 1", buf_rst); end
        @(posedge clk); #1;
        rst = 1'b1;
        checks++; if (win_vld !== 1'b0 || win_x !== 10'd0 || win_y !== 10'd0 || frame_done !== 1'b0 ||
                      sync_err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got vld=%b (%0d,%0d) fd=%b se=%b busy=%b want all 0",
                               win_vld, win_x, win_y, frame_done, sync_err, busy); end
        repeat (4) @(posedge clk); #1;
        checks++; if (fd_n - f !== 0) begin errors++; $display("FAIL midrst_no_fd: got %0d want 0", fd_n - f); end
        b = win_n; f = fd_n;
        send_range(0, 47);
        drain_wait();
        checks++; if (win_n - b !== 24 || fd_n - f !== 1) begin
            errors++; $display("FAIL midrst_frame: got wins=%0d fd=%0d want 24,1", win_n - b, fd_n - f); end
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (wx[(b+k)%512] !== k%6+1 || wy[(b+k)%512] !== k/6+1) begin
                errors++; $display("FAIL midrst_win_order[%0d]: got (%0d,%0d) want (%0d,%0d)", k, wx[(b+k)%512], wy[(b+k)%512], k%6+1, k/6+1); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_idle_drop();
        test_backpressure();
        test_resync();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nms_ctrl.md
Name: nms_ctrl

Overview:
Sequencing controller for the 3x3 NMS line-buffer/window datapath. It accepts the corner-score pixel stream from the FAST score stage with a valid/ready handshake and tags each pixel with x/y coordinates. It drives the window buffer's ce, data and reset, so the buffer only shifts on accepted pixels. It flags which buffer outputs are complete interior windows, publishes their centre coordinates to the NMS comparator under backpressure, and handles frame start, frame end and resynchronisation.

Parameters:
COL_NUM, 640, pixels per line (2..1023)
ROW_NUM, 480, lines per frame (2..1023)
NMS_SIZE, 3, window size; only 3 supported (elaboration error otherwise)
CW, 10, coordinate field width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
in_valid  in  1  upstream pixel valid
in_ready  out  1  upstream pixel accepted when in_valid&&in_ready
in_sof  in  1  first pixel of frame
in_corner  in  1  iscorner flag
in_score  in  13  corner score
buf_ce  out  1  window buffer shift enable
buf_rst  out  1  window buffer reset, active-high
buf_data  out  34  {x(10),y(10),iscorner(1),score(13)} to buffer data_in
win_vld  out  1  buffer window is a complete interior window
win_ready  in  1  comparator consumed window
win_x  out  10  window centre column
win_y  out  10  window centre row
frame_done  out  1  one-cycle pulse after last window handshake
sync_err  out  1  one-cycle pulse on mid-frame sof
busy  out  1  state != IDLE

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, x_cnt=y_cnt=0. win_vld, win_x, win_y, frame_done and sync_err are 0. buf_rst=1 combinationally while rst==0.
- buf_rst = !rst || state==RESYNC.
- buf_data is combinational {x_cnt, y_cnt, in_corner, in_score}.
- buf_ce = in_valid && in_ready && (state==RUN || (state==IDLE && in_sof)).
- IDLE:
  - in_ready=1.
  - Beats without sof are consumed and dropped; no buf_ce.
  - A sof beat is written at (0,0); the counters advance and the state goes to RUN.
- RUN:
  - in_ready = !win_vld || win_ready.
  - Each accepted beat advances x_cnt. At COL_NUM-1, x_cnt wraps to 0 and y_cnt increments.
  - Accepting (COL_NUM-1, ROW_NUM-1) moves the state to DRAIN.
- Mid-frame sof: in_valid && in_sof in RUN with (x_cnt,y_cnt) != (0,0).
  - in_ready=0 and the beat is not consumed.
  - sync_err pulses; the state goes to RESYNC.
  - Any pending win_vld is cleared.
- RESYNC: one cycle. in_ready=0, buf_rst=1, counters cleared, then IDLE, which accepts the held sof beat next cycle.
- DRAIN:
  - in_ready=0.
  - On the win_vld && win_ready handshake, frame_done pulses next cycle and the state returns to IDLE.
  - If win_vld is 0 on entry to DRAIN, go straight to IDLE with a frame_done pulse.
- Window tagging:
  - Latency is 1 cycle. On the cycle after buf_ce accepts pixel (c,r) with c>=2 and r>=2, win_vld=1, win_x=c-1, win_y=r-1.
  - Centres therefore span x in 1..COL_NUM-2 and y in 1..ROW_NUM-2. Border centres are never flagged.
  - win_vld/win_x/win_y hold stable until handshake. The buffer cannot shift while a window is pending, because in_ready gates buf_ce.
  - Handshake with a simultaneous qualifying buf_ce: new window loaded. Handshake with no qualifying buf_ce: win_vld cleared.
  - A non-qualifying buf_ce (c<2 or r<2) while win_vld=0 leaves win_vld=0.
- Counter arithmetic: unsigned CW-bit; wrap compare against COL_NUM-1 and ROW_NUM-1. The row counter does not wrap inside a frame.
- Reset mid-frame: immediate return to reset values next cycle; pending window dropped, no frame_done.

Decomposition:
- Package nms_pkg holds:
  - CW and score width 13.
  - Pixel field offsets: X_LSB=24, Y_LSB=14, CORNER_BIT=13, SCORE_LSB=0.
  - State encoding: IDLE, RUN, DRAIN, RESYNC.
- One sub-module, nms_pos_cnt: column/row counter with enable, clear, last_col and last_pix flags.

Test Plan:
(Use COL_NUM=8, ROW_NUM=6.)
- Clean frame, win_ready tied 1, 48 back-to-back beats with sof on beat 0 -> exactly 24 win_vld cycles; first (1,1) on the cycle after beat (2,2); last (6,4); frame_done pulses once; in_ready never drops.
- Backpressure, win_ready=0 for 5 cycles at window (3,2) -> win_vld/win_x=3/win_y=2 held; in_ready=0 and buf_ce=0 throughout; the stream resumes with no lost or duplicated window (24 total).
- Non-sof beats in IDLE (3 beats) then a sof frame -> 3 beats dropped, buf_ce=0 for them; frame tags start at (0,0).
- sof injected at pixel (5,3) -> sync_err pulses; buf_rst high for exactly 1 cycle; pending window dropped; the sof beat is then written as (0,0); the next full frame yields 24 windows.
- rst=0 for 1 cycle at pixel (4,4) -> all outputs 0, buf_rst=1 that cycle, no frame_done; a subsequent frame behaves as clean.
- buf_data check at pixel (7,5) with corner=1, score=0x1ABC -> buf_data = {10'd7, 10'd5, 1'b1, 13'h1ABC}.
